// File: rtl/mux_gates_pkg.sv
// Shared definitions for the mux-gate self-test: FSM states, sizes, y_in bit
// positions and the golden gate function.
// Purely declarative; no latency and no flow control.
package mux_gates_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_VEC = 4;
    localparam int GATE_W  = 7;

    // Bit positions inside the 7-bit gate output word (and is the MSB).
    localparam int IDX_AND  = 6;
    localparam int IDX_OR   = 5;
    localparam int IDX_NOT  = 4;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    function automatic logic [GATE_W-1:0] golden_gates(input logic a, input logic b);
        logic [GATE_W-1:0] g;
        g           = '0;
        g[IDX_AND]  = a & b;
        g[IDX_OR]   = a | b;
        g[IDX_NOT]  = ~a;
        g[IDX_NAND] = ~(a & b);
        g[IDX_NOR]  = ~(a | b);
        g[IDX_XOR]  = a ^ b;
        g[IDX_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/mux_gates_bist_golden.sv
// gate_golden_model: expected outputs of the gate block for a given a/b.
// Purely combinational, zero latency; no flow control.
// Ports: a, b in; expected[6:0] out in y_in bit order.
module gate_golden_model
    import mux_gates_pkg::*;
(
    input  logic              a,
    input  logic              b,
    output logic [GATE_W-1:0] expected
);

    assign expected = golden_gates(a, b);

endmodule

// File: rtl/mux_gates_bist.sv
// Self-test sequencer/checker: drives a/b through 00,01,10,11 and compares y_in to the golden model.
// Each vector takes SETTLE_CYCLES+2 cycles (DRIVE, SETTLE x N, CHECK); results are registered.
// start is honoured only in IDLE/DONE and ignored while busy; there is no queuing.
// Ports: clk/rst_n; start in; a/b stimulus out; y_in gate outputs in;
//        busy/done/pass status; fail_vec, fail_bits, err_count result registers.
module mux_gates_bist
    import mux_gates_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ITERATIONS    = 1,
    parameter int ERR_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               a,
    output logic               b,
    input  logic [GATE_W-1:0]  y_in,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_VEC-1:0] fail_vec,
    output logic [GATE_W-1:0]  fail_bits,
    output logic [ERR_W-1:0]   err_count
);

    // Settle counter holds SETTLE_CYCLES-1 down to 0; keep at least one bit.
    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int ITER_W = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    state_t             state_q, state_d;
    logic [1:0]         vec_q, vec_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [NUM_VEC-1:0] fail_vec_q, fail_vec_d;
    logic [GATE_W-1:0]  fail_bits_q, fail_bits_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [GATE_W-1:0]  expected;
    logic [GATE_W-1:0]  mask;
    logic [ERR_W-1:0]   err_upd;

    // Golden model sees the registered stimulus, so in CHECK it matches
    // exactly what the gate block has been driven with.
    gate_golden_model u_golden (
        .a        (a_q),
        .b        (b_q),
        .expected (expected)
    );

    assign mask = y_in ^ expected;

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        iter_d      = iter_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_vec_d  = fail_vec_q;
        fail_bits_d = fail_bits_q;
        err_d       = err_q;

        // Error count after this CHECK's sample, saturating at all-ones.
        err_upd = err_q;
        if ((mask != '0) && (err_q != '1)) begin
            err_upd = err_q + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    fail_vec_d  = '0;
                    fail_bits_d = '0;
                    err_d       = '0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    vec_d       = '0;
                    iter_d      = '0;
                    busy_d      = 1'b1;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                a_d = vec_q[1];
                b_d = vec_q[0];
                if (SETTLE_CYCLES == 0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CHECK: begin
                if (mask != '0) begin
                    fail_vec_d[vec_q] = 1'b1;
                    fail_bits_d       = fail_bits_q | mask;
                end
                err_d = err_upd;
                if (vec_q != 2'd3) begin
                    vec_d   = vec_q + 2'd1;
                    state_d = DRIVE;
                end else if (iter_q != ITER_W'(ITERATIONS - 1)) begin
                    // iter counts up from 0, so inequality marks "more passes left".
                    iter_d  = iter_q + 1'b1;
                    vec_d   = '0;
                    state_d = DRIVE;
                end else begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_upd == '0);
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            iter_q      <= '0;
            cnt_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_vec_q  <= '0;
            fail_bits_q <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            iter_q      <= iter_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_vec_q  <= fail_vec_d;
            fail_bits_q <= fail_bits_d;
            err_q       <= err_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_vec  = fail_vec_q;
    assign fail_bits = fail_bits_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_mux_gates_bist.sv
// Bench for mux_gates_bist: three instances (settle 2/iter 1, settle 2/iter 3, settle 0/iter 1)
// each wired to a gate block model whose outputs can be corrupted per input vector.
// Expected results come from an arithmetic truth-table model and per-vector fault tables.
module tb_mux_gates_bist;

    localparam int NDUT = 3;
    localparam int S_P [NDUT] = '{2, 2, 0};
    localparam int I_P [NDUT] = '{1, 3, 1};

    logic       clk;
    logic       rst_n;
    logic       start_s     [NDUT];
    logic       a_s         [NDUT];
    logic       b_s         [NDUT];
    logic [6:0] y_s         [NDUT];
    logic       busy_s      [NDUT];
    logic       done_s      [NDUT];
    logic       pass_s      [NDUT];
    logic [3:0] fail_vec_s  [NDUT];
    logic [6:0] fail_bits_s [NDUT];
    logic [7:0] err_s       [NDUT];

    // Per-instance, per-vector XOR corruption applied to the gate block outputs.
    logic [6:0] flip [NDUT][4];

    int n_chk  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_gates_bist #(.SETTLE_CYCLES(2), .ITERATIONS(1), .ERR_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .a(a_s[0]), .b(b_s[0]), .y_in(y_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .fail_vec(fail_vec_s[0]),
        .fail_bits(fail_bits_s[0]), .err_count(err_s[0]));

    mux_gates_bist #(.SETTLE_CYCLES(2), .ITERATIONS(3), .ERR_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .a(a_s[1]), .b(b_s[1]), .y_in(y_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .fail_vec(fail_vec_s[1]),
        .fail_bits(fail_bits_s[1]), .err_count(err_s[1]));

    mux_gates_bist #(.SETTLE_CYCLES(0), .ITERATIONS(1), .ERR_W(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .a(a_s[2]), .b(b_s[2]), .y_in(y_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .fail_vec(fail_vec_s[2]),
        .fail_bits(fail_bits_s[2]), .err_count(err_s[2]));

    // Truth table by counting ones among {a,b}: and=2 ones, or>=1, xor=exactly 1.
    function automatic logic [6:0] ref_gates(input int v);
        int av;
        int bv;
        int s;
        logic [6:0] r;
        av   = (v >> 1) & 1;
        bv   = v & 1;
        s    = av + bv;
        r[6] = (s == 2);
        r[5] = (s >= 1);
        r[4] = (av == 0);
        r[3] = (s != 2);
        r[2] = (s == 0);
        r[1] = (s == 1);
        r[0] = (s != 1);
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NDUT; i++) begin
            y_s[i] = ref_gates(int'({a_s[i], b_s[i]})) ^ flip[i][{a_s[i], b_s[i]}];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Start instance d, follow the run cycle by cycle and check results at DONE.
    task automatic run_and_check(input int d, input bit glitch, input string tag);
        int run;
        int per;
        int busy_cnt;
        int done_t;
        int ab_bad;
        int nz;
        logic [3:0] exp_fv;
        logic [6:0] exp_fb;
        int exp_ec;

        per    = S_P[d] + 2;
        run    = 4 * I_P[d] * per;
        exp_fv = '0;
        exp_fb = '0;
        nz     = 0;
        for (int k = 0; k < 4; k++) begin
            if (flip[d][k] != 7'd0) begin
                exp_fv[k] = 1'b1;
                exp_fb    = exp_fb | flip[d][k];
                nz++;
            end
        end
        exp_ec = I_P[d] * nz;
        if (exp_ec > 255) exp_ec = 255;

        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[d] = 1'b0;
        // First DRIVE cycle: results already cleared, busy up.
        check_val({tag, " clear"},
                  {10'd0, done_s[d], busy_s[d], pass_s[d], fail_vec_s[d], fail_bits_s[d], err_s[d]},
                  {10'd0, 1'b0, 1'b1, 1'b0, 4'd0, 7'd0, 8'd0});

        busy_cnt = 0;
        done_t   = -1;
        ab_bad   = 0;
        for (int t = 0; t < run + 20; t++) begin
            if (t > 0) @(negedge clk);
            if (glitch && t == 5) start_s[d] = 1'b1;
            if (t == 6) start_s[d] = 1'b0;
            if (t >= 1 && int'({a_s[d], b_s[d]}) != ((t - 1) / per) % 4) ab_bad++;
            if (done_s[d]) begin
                done_t = t;
                break;
            end
            if (busy_s[d]) busy_cnt++;
        end
        start_s[d] = 1'b0;

        check_val({tag, " done_latency"}, done_t, run);
        check_val({tag, " busy_cycles"}, busy_cnt, run);
        check_val({tag, " ab_sequence"}, ab_bad, 0);
        check_val({tag, " busy_low"}, busy_s[d], 1'b0);
        check_val({tag, " pass"}, pass_s[d], (exp_ec == 0));
        check_val({tag, " fail_vec"}, fail_vec_s[d], exp_fv);
        check_val({tag, " fail_bits"}, fail_bits_s[d], exp_fb);
        check_val({tag, " err_count"}, err_s[d], exp_ec);
    endtask

    task automatic clear_flip(input int d);
        for (int k = 0; k < 4; k++) flip[d][k] = 7'd0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            start_s[i] = 1'b0;
            clear_flip(i);
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check_val($sformatf("reset_state%0d", i),
                      {9'd0, a_s[i], b_s[i], busy_s[i], done_s[i], pass_s[i],
                       fail_vec_s[i], fail_bits_s[i], err_s[i]},
                      32'd0);
        end
        rst_n = 1'b1;

        // Correct gate block, settle 2: 16 busy cycles and a clean pass.
        run_and_check(0, 1'b0, "good_s2");

        // xor stuck-at-0: only vectors 01 and 10 expect xor=1. Started from DONE,
        // with a start pulse mid-run that must be ignored.
        for (int k = 0; k < 4; k++) flip[0][k] = ref_gates(k) & 7'b0000010;
        run_and_check(0, 1'b1, "xor_sa0");

        // Three passes with nand inverted on every vector: 12 errors, 48 cycles.
        for (int k = 0; k < 4; k++) flip[1][k] = 7'b0001000;
        run_and_check(1, 1'b0, "nand_inv_x3");

        // Zero settle: 2 cycles per vector.
        run_and_check(2, 1'b0, "good_s0");

        // Reset during SETTLE of vector 2 (first SETTLE cycle is 9 cycles after the first DRIVE).
        clear_flip(0);
        flip[0][1] = 7'b1000000;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (9) @(negedge clk);
        check_val("mid_run_vec2", {a_s[0], b_s[0], busy_s[0]}, 3'b101);
        rst_n = 1'b0;
        #1;
        check_val("abort_reset",
                  {9'd0, a_s[0], b_s[0], busy_s[0], done_s[0], pass_s[0],
                   fail_vec_s[0], fail_bits_s[0], err_s[0]},
                  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_flip(0);
        run_and_check(0, 1'b0, "after_abort");

        // Randomized fault patterns across all instances.
        for (int r = 0; r < 8; r++) begin
            int d;
            d = $urandom_range(0, NDUT - 1);
            for (int k = 0; k < 4; k++) begin
                flip[d][k] = ($urandom_range(0, 1) == 1) ? 7'($urandom) : 7'd0;
            end
            run_and_check(d, 1'($urandom_range(0, 1)), $sformatf("rand%0d_dut%0d", r, d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
